// File: rtl/cmc_array_sequencer.sv
// Soft-start/soft-stop enable sequencer for an array of PMOS current-mirror unit cells.
// Optional dynamic element matching rotation is built when CMC_SEQ_DEM_EN is defined.
module cmc_array_sequencer #(
  parameter int unsigned N_CELLS       = 20,
  parameter int unsigned CW            = 5,
  parameter int unsigned STEP_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [CW-1:0]      req_code,
  input  logic               abort,
  output logic [N_CELLS-1:0] cell_en,
  output logic [CW-1:0]      cur_code,
  output logic               busy,
  output logic               done,
  output logic               err_range
);

  localparam int unsigned SW = $clog2(STEP_CYCLES + 1);
  localparam int unsigned TW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] N_CODE      = CW'(N_CELLS);
  localparam logic [SW-1:0] STEP_LAST   = SW'(STEP_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state, state_next;
  logic [CW-1:0]      target, target_next;
  logic [CW-1:0]      cur_next;
  logic [CW-1:0]      clamped;
  logic [CW-1:0]      step_code;
  logic [SW-1:0]      step_cnt, step_next;
  logic [TW-1:0]      settle_cnt, settle_next;
  logic               err_next;
  logic [N_CELLS-1:0] therm;
  logic [N_CELLS-1:0] en_next;

`ifdef CMC_SEQ_DEM_EN
  localparam logic [CW:0] N_WIDE = (CW+1)'(N_CELLS);
  logic [CW-1:0]        rot_ptr, rot_next;
  logic [CW-1:0]        win_base, base_next;
  logic [CW:0]          rot_sum;
  logic [2*N_CELLS-1:0] rot_dbl;
`endif

  // Next-state, ramp stepping and settle timing
  always_comb begin
    state_next  = state;
    target_next = target;
    cur_next    = cur_code;
    step_next   = step_cnt;
    settle_next = settle_cnt;
    err_next    = 1'b0;
    clamped     = (req_code > N_CODE) ? N_CODE : req_code;
    step_code   = (target > cur_code) ? cur_code + CW'(1) : cur_code - CW'(1);
`ifdef CMC_SEQ_DEM_EN
    base_next   = win_base;
    rot_next    = rot_ptr;
    rot_sum     = {1'b0, rot_ptr} + {1'b0, cur_code};
`endif
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          target_next = clamped;
          err_next    = (req_code > N_CODE);
          step_next   = '0;
          settle_next = '0;
          state_next  = (clamped == cur_code) ? SETTLE : RAMP;
`ifdef CMC_SEQ_DEM_EN
          // An empty window may be re-anchored at the rotation pointer
          if (cur_code == '0) base_next = rot_ptr;
`endif
        end
      end
      RAMP: begin
        if (abort) begin
          target_next = cur_code;
          settle_next = '0;
          state_next  = SETTLE;
        end else if (step_cnt == STEP_LAST) begin
          step_next = '0;
          cur_next  = step_code;
          if (step_code == target) begin
            settle_next = '0;
            state_next  = SETTLE;
          end
        end else begin
          step_next = step_cnt + SW'(1);
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_next = DONE;
        else settle_next = settle_cnt + TW'(1);
      end
      DONE: begin
        state_next = IDLE;
`ifdef CMC_SEQ_DEM_EN
        // Window keeps its base, so cell_en does not move across this edge
        rot_next = (rot_sum >= N_WIDE) ? CW'(rot_sum - N_WIDE) : CW'(rot_sum);
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Enable pattern for the next code
  always_comb begin
    therm = '0;
    for (int i = 0; i < int'(N_CELLS); i++) therm[i] = (CW'(i) < cur_next);
`ifdef CMC_SEQ_DEM_EN
    rot_dbl = {therm, therm} << base_next;
    en_next = rot_dbl[2*N_CELLS-1:N_CELLS];
`else
    en_next = therm;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      target     <= '0;
      cur_code   <= '0;
      step_cnt   <= '0;
      settle_cnt <= '0;
      cell_en    <= '0;
      busy       <= 1'b0;
      req_ready  <= 1'b1;
      done       <= 1'b0;
      err_range  <= 1'b0;
`ifdef CMC_SEQ_DEM_EN
      rot_ptr    <= '0;
      win_base   <= '0;
`endif
    end else begin
      state      <= state_next;
      target     <= target_next;
      cur_code   <= cur_next;
      step_cnt   <= step_next;
      settle_cnt <= settle_next;
      cell_en    <= en_next;
      busy       <= (state_next != IDLE);
      req_ready  <= (state_next == IDLE);
      done       <= (state_next == DONE);
      err_range  <= err_next;
`ifdef CMC_SEQ_DEM_EN
      rot_ptr    <= rot_next;
      win_base   <= base_next;
`endif
    end
  end

endmodule

// File: tb/tb_cmc_array_sequencer.sv
// Scoreboard bench for cmc_array_sequencer: a transaction model predicts each
// step, error pulse and done pulse with its cycle; a monitor pops and compares.
module tb_cmc_array_sequencer;

  localparam int N      = 20;
  localparam int CW     = 5;
  localparam int STEP   = 4;
  localparam int SETTLE = 8;

  localparam int EV_ERR  = 0;
  localparam int EV_STEP = 1;
  localparam int EV_DONE = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [CW-1:0] req_code;
  logic          abort;
  logic [N-1:0]  cell_en;
  logic [CW-1:0] cur_code;
  logic          busy;
  logic          done;
  logic          err_range;

  cmc_array_sequencer #(
    .N_CELLS(N), .CW(CW), .STEP_CYCLES(STEP), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_code(req_code), .abort(abort), .cell_en(cell_en), .cur_code(cur_code),
    .busy(busy), .done(done), .err_range(err_range)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           kind;
    int           cyc;
    int           code;
    logic [N-1:0] en;
  } ev_t;

  ev_t          exp_q[$];
  int           cycle     = 0;
  int           checks    = 0;
  int           errors    = 0;
  int           model_cur = 0;
  bit           mon_en    = 1'b0;
  int           prev_code = 0;
  logic [N-1:0] prev_en   = '0;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [N-1:0] therm(input int k);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) if (i < k) v[i] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cycle, got, exp);
    end
  endtask

  task automatic pop_check(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event kind=%0d at cycle %0d: got event expected none", kind, cycle);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", kind, e.kind);
    check("event_cycle", cycle, e.cyc);
    check("event_code", int'(cur_code), e.code);
    check("event_cell_en", cell_en, e.en);
    if (kind == EV_DONE) check("ready_low_in_done", req_ready, 0);
  endtask

  // Monitor: every observable output event is matched against the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (err_range) pop_check(EV_ERR);
      if (int'(cur_code) != prev_code) begin
        pop_check(EV_STEP);
        check("one_bit_change", $countones(prev_en ^ cell_en), 1);
      end
      if (done) pop_check(EV_DONE);
    end
    prev_code = int'(cur_code);
    prev_en   = cell_en;
  end

  task automatic push(input int kind, input int cyc, input int code);
    ev_t e;
    e.kind = kind;
    e.cyc  = cyc;
    e.code = code;
    e.en   = therm(code);
    exp_q.push_back(e);
  endtask

  task automatic wait_ready();
    int guard = 0;
    @(negedge clk);
    while (!req_ready) begin
      @(negedge clk);
      if (++guard > 500) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout: got req_ready=0 expected 1 within 500 cycles");
        return;
      end
    end
  endtask

  // Issue one request; abort_after>0 asserts abort on that many edges after acceptance
  task automatic issue(input int code, input int abort_after);
    int c, tgt, mag, dir, nsteps, end_edge, abort_edge, done_edge, fin;
    wait_ready();
    req_valid = 1'b1;
    req_code  = CW'(code);
    c   = cycle + 1;
    tgt = (code > N) ? N : code;
    mag = (tgt > model_cur) ? tgt - model_cur : model_cur - tgt;
    dir = (tgt > model_cur) ? 1 : -1;
    nsteps     = mag;
    end_edge   = c + mag * STEP;
    abort_edge = -1;
    if (abort_after > 0 && mag > 0 && abort_after <= mag * STEP) begin
      nsteps     = (abort_after - 1) / STEP;
      abort_edge = c + abort_after;
      end_edge   = abort_edge;
    end
    if (code > N) push(EV_ERR, c, model_cur);
    for (int k = 1; k <= nsteps; k++) push(EV_STEP, c + k * STEP, model_cur + dir * k);
    fin       = model_cur + dir * nsteps;
    done_edge = end_edge + SETTLE + 1;
    push(EV_DONE, done_edge, fin);
    model_cur = fin;
    forever begin
      @(negedge clk);
      if (cycle > done_edge) begin
        req_valid = 1'b0;
        abort     = 1'b0;
        break;
      end
      // Decide inputs for the coming edge; stray traffic only where it must be ignored
      req_valid = !req_ready && ($urandom_range(0, 3) == 0);
      req_code  = CW'($urandom_range(0, 31));
      if (cycle + 1 == abort_edge) abort = 1'b1;
      else abort = (cycle + 1 > end_edge) && ($urandom_range(0, 2) == 0);
    end
    check("ready_after_done", req_ready, 1);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    int guard;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_code  = '0;
    abort     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_cell_en", cell_en, 0);
    check("rst_cur_code", int'(cur_code), 0);
    check("rst_done", done, 0);
    check("rst_err", err_range, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    issue(5, 0);
    check("ramp5_cell_en", cell_en, 20'h0001F);
    issue(2, 0);
    check("down2_cell_en", cell_en, 20'h00003);
    issue(25, 0);
    check("clamp_cell_en", cell_en, 20'hFFFFF);
    check("clamp_cur_code", int'(cur_code), 20);
    issue(0, 0);
    issue(10, 26);
    check("abort_cur_code", int'(cur_code), 6);
    check("abort_cell_en", cell_en, 20'h0003F);
    issue(6, 0);

    // Reset in the middle of a ramp from 6 toward 0
    wait_ready();
    mon_en    = 1'b0;
    req_valid = 1'b1;
    req_code  = CW'(0);
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (cur_code != CW'(3) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("reach_code3", int'(cur_code), 3);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_cell_en", cell_en, 0);
    check("midrst_cur_code", int'(cur_code), 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", req_ready, 1);
    rst_n     = 1'b1;
    model_cur = 0;
    exp_q.delete();
    @(negedge clk);
    mon_en = 1'b1;

    issue(0, 0);
    issue(20, 0);
    check("full_cell_en", cell_en, 20'hFFFFF);

    for (int t = 0; t < 30; t++) begin
      int code, ab;
      code = $urandom_range(0, 31);
      ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 80) : 0;
      issue(code, ab);
      check("rand_cur_code", int'(cur_code), model_cur);
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion expected finish before 40000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
